// File: rtl/clause_vote_accumulator.sv
// Clause vote accumulator: sums polarity-weighted clause outputs over one frame,
// clamps the class sum to +/-THRESHOLD and holds it behind a valid/ack handshake
// while stop_flag freezes the upstream clause counter.
module clause_vote_accumulator #(
    parameter int unsigned NUM_CLAUSES = 64,
    parameter int unsigned SUM_W       = 8,
    parameter int unsigned THRESHOLD   = 15
) (
    input  logic                    clk,
    input  logic                    rst_flag_n,
    input  logic                    in_valid,
    input  logic [5:0]              clause_idx,
    input  logic                    clause_out,
    input  logic                    sum_ack,
    output logic                    stop_flag,
    output logic                    sum_valid,
    output logic signed [SUM_W-1:0] class_sum,
    output logic                    class_vote,
    output logic                    seq_error
);

    localparam logic [5:0]              LastIdx = 6'(NUM_CLAUSES - 1);
    localparam logic signed [SUM_W-1:0] TPos    = SUM_W'(THRESHOLD);
    localparam logic signed [SUM_W-1:0] TNeg    = -TPos;

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e                  state_q, state_d;
    logic signed [SUM_W-1:0] acc_q, acc_d;
    logic [5:0]              expected_q, expected_d;
    logic                    seq_error_q, seq_error_d;
    logic                    sum_valid_q, sum_valid_d;
    logic                    stop_q, stop_d;
    logic signed [SUM_W-1:0] class_sum_q, class_sum_d;
    logic                    class_vote_q, class_vote_d;

    logic [1:0]              rst_sync_q;
    logic                    rst_n;
    logic signed [SUM_W-1:0] contrib;
    logic signed [SUM_W-1:0] acc_sum;
    logic signed [SUM_W-1:0] final_sum;
    logic signed [SUM_W-1:0] clamped;
    logic                    finish;

    // Saturate only the presented result; the accumulator itself cannot overflow.
    function automatic logic signed [SUM_W-1:0] clamp_sum(input logic signed [SUM_W-1:0] v);
        if (v > TPos) begin
            return TPos;
        end else if (v < TNeg) begin
            return TNeg;
        end
        return v;
    endfunction

    // Reset asserts immediately but releases only after two clock edges.
    always_ff @(posedge clk or negedge rst_flag_n) begin
        if (!rst_flag_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Even index votes for the class, odd index votes against it.
    assign contrib = !clause_out ? '0 : (clause_idx[0] ? '1 : SUM_W'(1));
    assign acc_sum = acc_q + contrib;

    // Next-state and result computation.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        expected_d   = expected_q;
        seq_error_d  = 1'b0;
        sum_valid_d  = sum_valid_q;
        stop_d       = stop_q;
        class_sum_d  = class_sum_q;
        class_vote_d = class_vote_q;
        finish       = 1'b0;
        final_sum    = acc_sum;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (clause_idx == 6'd0) begin
                        acc_d     = contrib;
                        final_sum = contrib;
                        if (LastIdx == 6'd0) begin
                            finish = 1'b1;
                        end else begin
                            expected_d = 6'd1;
                            state_d    = StAccum;
                        end
                    end else begin
                        seq_error_d = 1'b1;
                    end
                end
            end
            StAccum: begin
                if (in_valid) begin
                    if (clause_idx == expected_q) begin
                        acc_d     = acc_sum;
                        final_sum = acc_sum;
                        if (clause_idx == LastIdx) begin
                            finish = 1'b1;
                        end else begin
                            expected_d = expected_q + 6'd1;
                        end
                    end else begin
                        seq_error_d = 1'b1;
                        if (clause_idx == 6'd0) begin
                            // Out-of-order index 0 restarts the frame with this sample.
                            acc_d      = contrib;
                            final_sum  = contrib;
                            expected_d = 6'd1;
                        end else begin
                            acc_d      = '0;
                            expected_d = 6'd0;
                            state_d    = StIdle;
                        end
                    end
                end
            end
            StHold: begin
                if (sum_ack && sum_valid_q) begin
                    state_d     = StIdle;
                    acc_d       = '0;
                    expected_d  = 6'd0;
                    sum_valid_d = 1'b0;
                    stop_d      = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        clamped = clamp_sum(final_sum);
        if (finish) begin
            state_d      = StHold;
            expected_d   = 6'd0;
            sum_valid_d  = 1'b1;
            stop_d       = 1'b1;
            class_sum_d  = clamped;
            class_vote_d = ~clamped[SUM_W-1];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            expected_q   <= 6'd0;
            seq_error_q  <= 1'b0;
            sum_valid_q  <= 1'b0;
            stop_q       <= 1'b0;
            class_sum_q  <= '0;
            class_vote_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            expected_q   <= expected_d;
            seq_error_q  <= seq_error_d;
            sum_valid_q  <= sum_valid_d;
            stop_q       <= stop_d;
            class_sum_q  <= class_sum_d;
            class_vote_q <= class_vote_d;
        end
    end

    assign stop_flag  = stop_q;
    assign sum_valid  = sum_valid_q;
    assign class_sum  = class_sum_q;
    assign class_vote = class_vote_q;
    assign seq_error  = seq_error_q;

endmodule
